// File: rtl/contador_param.sv
// WIDTH-bit up/down/step/load counter with a programmable wrap limit and optional saturation.
// Q, rco and load are all registered; arithmetic is carried out in WIDTH+1 bits, modulo (limit+1).
module contador_param #(
    parameter int WIDTH    = 4,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    localparam int W1 = WIDTH + 1;
    localparam logic [W1-1:0] STEP_X = W1'(STEP);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_STEP = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    logic [W1-1:0]    q_x;
    logic [W1-1:0]    lim_x;
    logic [W1-1:0]    mod_x;
    logic [W1-1:0]    step_red;
    logic [W1-1:0]    step_wrap;
    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             load_next;

    // Reducing STEP mod (limit+1) first keeps the wrapped step correct when STEP > limit+1.
    always_comb begin
        q_x       = {1'b0, Q};
        lim_x     = {1'b0, limit};
        mod_x     = lim_x + W1'(1);
        step_red  = STEP_X % mod_x;
        step_wrap = (q_x + mod_x - step_red) % mod_x;
    end

    always_comb begin
        q_next    = Q;
        rco_next  = 1'b0;
        load_next = 1'b0;
        case (mode_t'(mode))
            MODE_UP: begin
                if (q_x >= lim_x) begin
                    q_next   = (SATURATE != 0) ? limit : '0;
                    rco_next = 1'b1;
                end else begin
                    q_next = Q + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (Q == '0) begin
                    q_next   = (SATURATE != 0) ? '0 : limit;
                    rco_next = 1'b1;
                end else begin
                    q_next = Q - WIDTH'(1);
                end
            end
            MODE_STEP: begin
                if (q_x >= STEP_X) begin
                    q_next = WIDTH'(q_x - STEP_X);
                end else begin
                    q_next   = (SATURATE != 0) ? '0 : WIDTH'(step_wrap);
                    rco_next = 1'b1;
                end
            end
            MODE_LOAD: begin
                q_next    = D;
                load_next = 1'b1;
            end
            default: begin
                q_next = Q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else if (enable) begin
            Q    <= q_next;
            rco  <= rco_next;
            load <= load_next;
        end else begin
            rco  <= 1'b0;
            load <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_param.sv
// Directed vector bench for contador_param: a wrapping instance (SATURATE=0) driven from a vector
// table and hand sequences, plus a saturating instance sharing the same inputs.
module tb_contador_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] D = '0;
    logic [3:0] limit = 4'd15;
    logic [3:0] q_w, q_s;
    logic       rco_w, rco_s, load_w, load_s;

    int unsigned total = 0;
    int unsigned bad = 0;

    contador_param #(.WIDTH(4), .STEP(3), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D), .limit(limit),
        .Q(q_w), .rco(rco_w), .load(load_w)
    );

    contador_param #(.WIDTH(4), .STEP(3), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D), .limit(limit),
        .Q(q_s), .rco(rco_s), .load(load_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] md;
        logic [3:0] d;
        logic [3:0] lim;
        logic [3:0] exp_q;
        logic       exp_rco;
        logic       exp_load;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic [1:0] md, input logic [3:0] d,
                                input logic [3:0] lim, input logic [3:0] eq,
                                input logic er, input logic el);
        vec_t v;
        v.en = en; v.md = md; v.d = d; v.lim = lim;
        v.exp_q = eq; v.exp_rco = er; v.exp_load = el;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic en, input logic [1:0] md, input logic [3:0] d,
                        input logic [3:0] lim);
        @(negedge clk);
        enable = en; mode = md; D = d; limit = lim;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Scenario: up count over the full range, wrap with single-cycle rco
        add(1, 2'b11, 4'd0, 4'd15, 4'd0, 0, 1);
        for (int i = 1; i <= 15; i++) add(1, 2'b00, 4'd0, 4'd15, 4'(i), 0, 0);
        add(1, 2'b00, 4'd0, 4'd15, 4'd0, 1, 0);
        add(1, 2'b00, 4'd0, 4'd15, 4'd1, 0, 0);
        // Down by one wrapping to limit
        add(1, 2'b11, 4'd1, 4'd9, 4'd1, 0, 1);
        add(1, 2'b01, 4'd0, 4'd9, 4'd0, 0, 0);
        add(1, 2'b01, 4'd0, 4'd9, 4'd9, 1, 0);
        add(1, 2'b01, 4'd0, 4'd9, 4'd8, 0, 0);
        // Down by STEP with wrap
        add(1, 2'b11, 4'd4, 4'd15, 4'd4, 0, 1);
        add(1, 2'b10, 4'd0, 4'd15, 4'd1, 0, 0);
        add(1, 2'b10, 4'd0, 4'd15, 4'd14, 1, 0);
        add(1, 2'b10, 4'd0, 4'd15, 4'd11, 0, 0);
        add(1, 2'b11, 4'd1, 4'd9, 4'd1, 0, 1);
        add(1, 2'b10, 4'd0, 4'd9, 4'd8, 1, 0);
        // STEP > limit+1: wrapped result re-reduced mod (limit+1)
        add(1, 2'b11, 4'd1, 4'd1, 4'd1, 0, 1);
        add(1, 2'b10, 4'd0, 4'd1, 4'd0, 1, 0);
        add(1, 2'b10, 4'd0, 4'd1, 4'd1, 1, 0);
        // Load, repeated load, hold, then up from above limit
        add(1, 2'b11, 4'd12, 4'd9, 4'd12, 0, 1);
        add(1, 2'b11, 4'd12, 4'd9, 4'd12, 0, 1);
        add(0, 2'b00, 4'd3, 4'd9, 4'd12, 0, 0);
        add(0, 2'b11, 4'd3, 4'd9, 4'd12, 0, 0);
        add(1, 2'b00, 4'd3, 4'd9, 4'd0, 1, 0);
        // Down from above limit counts normally
        add(1, 2'b11, 4'd14, 4'd9, 4'd14, 0, 1);
        add(1, 2'b01, 4'd0, 4'd9, 4'd13, 0, 0);
        // limit = 0
        add(1, 2'b11, 4'd0, 4'd0, 4'd0, 0, 1);
        add(1, 2'b00, 4'd0, 4'd0, 4'd0, 1, 0);
        add(1, 2'b01, 4'd0, 4'd0, 4'd0, 1, 0);
        add(1, 2'b10, 4'd0, 4'd0, 4'd0, 1, 0);
        // Limit change mid-count: no retroactive wrap
        add(1, 2'b11, 4'd7, 4'd15, 4'd7, 0, 1);
        add(1, 2'b00, 4'd0, 4'd5, 4'd0, 1, 0);

        reset = 1'b1;
        #12;
        check("reset_q", q_w, 0);
        check("reset_rco", rco_w, 0);
        check("reset_load", load_w, 0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset mid-count
        for (int i = 1; i <= 5; i++) step(1, 2'b00, 4'd0, 4'd15);
        check("pre_reset_q", q_w, 5);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_q", q_w, 0);
        check("async_reset_rco", rco_w, 0);
        check("async_reset_load", load_w, 0);
        @(posedge clk);
        #1;
        check("held_reset_q", q_w, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_q", q_w, 1);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].md, vecs[i].d, vecs[i].lim);
            check($sformatf("vec%0d_q", i), q_w, vecs[i].exp_q);
            check($sformatf("vec%0d_rco", i), rco_w, vecs[i].exp_rco);
            check($sformatf("vec%0d_load", i), load_w, vecs[i].exp_load);
        end

        // Saturating instance, limit = 9
        step(1, 2'b11, 4'd9, 4'd9);
        check("sat_load_q", q_s, 9);
        check("sat_load_flag", load_s, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b00, 4'd0, 4'd9);
            check($sformatf("sat_up%0d_q", i), q_s, 9);
            check($sformatf("sat_up%0d_rco", i), rco_s, 1);
            check($sformatf("sat_up%0d_load", i), load_s, 0);
        end
        step(1, 2'b11, 4'd2, 4'd9);
        check("sat_load2_q", q_s, 2);
        step(1, 2'b10, 4'd0, 4'd9);
        check("sat_step_q", q_s, 0);
        check("sat_step_rco", rco_s, 1);
        step(1, 2'b01, 4'd0, 4'd9);
        check("sat_down_q", q_s, 0);
        check("sat_down_rco", rco_s, 1);
        step(1, 2'b11, 4'd5, 4'd9);
        step(1, 2'b10, 4'd0, 4'd9);
        check("sat_step_nowrap_q", q_s, 2);
        check("sat_step_nowrap_rco", rco_s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
